// File: rtl/segre_exception_controller.sv
// Trap/MRET sequencer: captures exception or interrupt context, flushes the
// pipeline, writes the CSR exception port, then redirects fetch to the handler.
module segre_exception_controller #(
    parameter int WORD_SIZE = 32,
    parameter int CAUSE_W   = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 exc_req_i,
    input  logic [CAUSE_W-1:0]   exc_cause_i,
    input  logic [WORD_SIZE-1:0] exc_pc_i,
    input  logic                 mret_i,
    input  logic                 irq_i,
    input  logic                 irq_en_i,
    input  logic [WORD_SIZE-1:0] irq_pc_i,
    input  logic [WORD_SIZE-1:0] mtvec_i,
    input  logic [WORD_SIZE-1:0] mepc_i,
    output logic                 exc_we_o,
    output logic [WORD_SIZE-1:0] w_data_mtvec_o,
    output logic [WORD_SIZE-1:0] w_data_mepc_o,
    output logic [WORD_SIZE-1:0] w_data_mcause_o,
    output logic                 flush_o,
    output logic                 stall_o,
    output logic                 pc_redirect_valid_o,
    output logic [WORD_SIZE-1:0] pc_redirect_o,
    output logic [15:0]          trap_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SAVE,
        REDIRECT,
        MRET
    } state_t;

    localparam logic [WORD_SIZE-1:0] IRQ_CAUSE =
        {1'b1, {(WORD_SIZE-1){1'b0}}} | WORD_SIZE'(11);

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] mepc_q, mepc_d;
    logic [WORD_SIZE-1:0] mcause_q, mcause_d;
    logic [WORD_SIZE-1:0] mtvec_w_q, mtvec_w_d;
    logic [WORD_SIZE-1:0] redirect_q, redirect_d;
    logic [15:0]          trap_count_q, trap_count_d;
    logic                 exc_we_q, exc_we_d;
    logic                 flush_q, flush_d;
    logic                 stall_q, stall_d;
    logic                 redirect_valid_q, redirect_valid_d;

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they belong to.
    always_comb begin
        state_d          = state_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtvec_w_d        = mtvec_w_q;
        redirect_d       = redirect_q;
        trap_count_d     = trap_count_q;
        exc_we_d         = 1'b0;
        flush_d          = 1'b0;
        stall_d          = 1'b0;
        redirect_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (exc_req_i) begin
                    state_d                 = FLUSH;
                    mepc_d                  = exc_pc_i;
                    mcause_d                = '0;
                    mcause_d[CAUSE_W-1:0]   = exc_cause_i;
                    flush_d                 = 1'b1;
                    stall_d                 = 1'b1;
                end else if (mret_i) begin
                    state_d          = MRET;
                    redirect_d       = mepc_i;
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                end else if (irq_i && irq_en_i) begin
                    state_d  = FLUSH;
                    mepc_d   = irq_pc_i;
                    mcause_d = IRQ_CAUSE;
                    flush_d  = 1'b1;
                    stall_d  = 1'b1;
                end
            end
            FLUSH: begin
                state_d   = SAVE;
                mtvec_w_d = mtvec_i;
                exc_we_d  = 1'b1;
                stall_d   = 1'b1;
            end
            SAVE: begin
                state_d          = REDIRECT;
                redirect_d       = {mtvec_i[WORD_SIZE-1:2], 2'b00};
                redirect_valid_d = 1'b1;
                stall_d          = 1'b1;
                trap_count_d     = trap_count_q + 16'd1;
            end
            REDIRECT: state_d = IDLE;
            MRET:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtvec_w_q        <= '0;
            redirect_q       <= '0;
            trap_count_q     <= '0;
            exc_we_q         <= 1'b0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtvec_w_q        <= mtvec_w_d;
            redirect_q       <= redirect_d;
            trap_count_q     <= trap_count_d;
            exc_we_q         <= exc_we_d;
            flush_q          <= flush_d;
            stall_q          <= stall_d;
            redirect_valid_q <= redirect_valid_d;
        end
    end

    assign exc_we_o            = exc_we_q;
    assign w_data_mtvec_o      = mtvec_w_q;
    assign w_data_mepc_o       = mepc_q;
    assign w_data_mcause_o     = mcause_q;
    assign flush_o             = flush_q;
    assign stall_o             = stall_q;
    assign pc_redirect_valid_o = redirect_valid_q;
    assign pc_redirect_o       = redirect_q;
    assign trap_count_o        = trap_count_q;

endmodule

// File: tb/tb_segre_exception_controller.sv
// Directed bench for segre_exception_controller with a cycle-schedule model.
module tb_segre_exception_controller;

    localparam int WS = 32;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          exc_req;
    logic [CW-1:0] exc_cause;
    logic [WS-1:0] exc_pc;
    logic          mret;
    logic          irq;
    logic          irq_en;
    logic [WS-1:0] irq_pc;
    logic [WS-1:0] mtvec;
    logic [WS-1:0] mepc;
    logic          exc_we;
    logic [WS-1:0] w_mtvec, w_mepc, w_mcause;
    logic          flush, stall, rvalid;
    logic [WS-1:0] rpc;
    logic [15:0]   tcount;

    segre_exception_controller #(.WORD_SIZE(WS), .CAUSE_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .exc_req_i(exc_req), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc),
        .mret_i(mret), .irq_i(irq), .irq_en_i(irq_en), .irq_pc_i(irq_pc),
        .mtvec_i(mtvec), .mepc_i(mepc),
        .exc_we_o(exc_we), .w_data_mtvec_o(w_mtvec), .w_data_mepc_o(w_mepc),
        .w_data_mcause_o(w_mcause), .flush_o(flush), .stall_o(stall),
        .pc_redirect_valid_o(rvalid), .pc_redirect_o(rpc),
        .trap_count_o(tcount)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: kind 0 = idle, 1 = trap, 2 = mret; off = cycles since acceptance.
    int          m_kind, m_off;
    logic [31:0] m_mepc, m_mcause, m_wtvec, m_redir;
    logic [15:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kind = 0; m_off = 0;
        m_mepc = '0; m_mcause = '0; m_wtvec = '0; m_redir = '0; m_count = '0;
    endtask

    task automatic model_step();
        if (m_kind == 0) begin
            if (exc_req) begin
                m_kind = 1; m_off = 1; m_mepc = exc_pc; m_mcause = 32'(exc_cause);
            end else if (mret) begin
                m_kind = 2; m_off = 1; m_redir = mepc;
            end else if (irq && irq_en) begin
                m_kind = 1; m_off = 1; m_mepc = irq_pc; m_mcause = 32'h8000_000B;
            end
        end else begin
            m_off++;
            if (m_kind == 1 && m_off == 2) m_wtvec = mtvec;
            if (m_kind == 1 && m_off == 3) begin
                m_redir = mtvec & ~32'h3;
                m_count = m_count + 16'd1;
            end
            if ((m_kind == 1 && m_off == 4) || (m_kind == 2 && m_off == 2)) m_kind = 0;
        end
    endtask

    task automatic compare_all();
        logic e_flush, e_we, e_valid, e_stall;
        e_flush = (m_kind != 0) && (m_off == 1);
        e_we    = (m_kind == 1) && (m_off == 2);
        e_valid = ((m_kind == 1) && (m_off == 3)) || ((m_kind == 2) && (m_off == 1));
        e_stall = (m_kind == 1);
        chk("m_flush", 32'(flush), 32'(e_flush));
        chk("m_exc_we", 32'(exc_we), 32'(e_we));
        chk("m_redirect_valid", 32'(rvalid), 32'(e_valid));
        chk("m_stall", 32'(stall), 32'(e_stall));
        chk("m_mepc", w_mepc, m_mepc);
        chk("m_mcause", w_mcause, m_mcause);
        chk("m_mtvec", w_mtvec, m_wtvec);
        chk("m_trap_count", 32'(tcount), 32'(m_count));
        if (e_valid) chk("m_redirect_pc", rpc, m_redir);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        if (!rst) compare_all();
    endtask

    task automatic clear_reqs();
        exc_req = 1'b0; mret = 1'b0; irq = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_we"},     32'(exc_we), 32'd0);
        chk({name, "_flush"},  32'(flush),  32'd0);
        chk({name, "_stall"},  32'(stall),  32'd0);
        chk({name, "_valid"},  32'(rvalid), 32'd0);
        chk({name, "_pc"},     rpc,         32'd0);
        chk({name, "_mepc"},   w_mepc,      32'd0);
        chk({name, "_mcause"}, w_mcause,    32'd0);
        chk({name, "_mtvec"},  w_mtvec,     32'd0);
        chk({name, "_count"},  32'(tcount), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        exc_cause = '0; exc_pc = '0; irq_en = 1'b0; irq_pc = '0;
        mtvec = 32'h803; mepc = '0;
        model_reset();
        #12;
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Exception: cause 2 at 0x100
        exc_req = 1'b1; exc_cause = 5'd2; exc_pc = 32'h100;
        tick(); clear_reqs();
        chk("e_flush", 32'(flush), 32'd1);
        chk("e_stall", 32'(stall), 32'd1);
        tick();
        chk("e_we", 32'(exc_we), 32'd1);
        chk("e_mepc", w_mepc, 32'h100);
        chk("e_mcause", w_mcause, 32'h2);
        chk("e_mtvec", w_mtvec, 32'h803);
        tick();
        chk("e_valid", 32'(rvalid), 32'd1);
        chk("e_pc", rpc, 32'h800);
        chk("e_count", 32'(tcount), 32'd1);
        tick();
        chk("e_idle_stall", 32'(stall), 32'd0);

        // Interrupt, then masked interrupt
        irq = 1'b1; irq_en = 1'b1; irq_pc = 32'h204;
        tick(); clear_reqs();
        tick();
        chk("i_we", 32'(exc_we), 32'd1);
        chk("i_mcause", w_mcause, 32'h8000_000B);
        chk("i_mepc", w_mepc, 32'h204);
        tick(); tick();
        irq = 1'b1; irq_en = 1'b0;
        repeat (4) tick();
        chk("i_masked_flush", 32'(flush), 32'd0);
        chk("i_masked_count", 32'(tcount), 32'd2);
        clear_reqs();

        // Simultaneous exception, mret and interrupt
        exc_req = 1'b1; exc_cause = 5'd5; exc_pc = 32'h300;
        mret = 1'b1; mepc = 32'h480; irq = 1'b1; irq_en = 1'b1;
        tick(); clear_reqs();
        chk("p_valid", 32'(rvalid), 32'd0);
        chk("p_stall", 32'(stall), 32'd1);
        tick();
        chk("p_mcause", w_mcause, 32'h5);
        chk("p_mepc", w_mepc, 32'h300);
        tick(); tick();

        // MRET
        mret = 1'b1; mepc = 32'h480;
        tick(); clear_reqs();
        chk("r_flush", 32'(flush), 32'd1);
        chk("r_valid", 32'(rvalid), 32'd1);
        chk("r_pc", rpc, 32'h480);
        chk("r_stall", 32'(stall), 32'd0);
        chk("r_we", 32'(exc_we), 32'd0);
        tick();
        chk("r_count", 32'(tcount), 32'd3);

        // Second exception while in SAVE is dropped
        exc_req = 1'b1; exc_cause = 5'd7; exc_pc = 32'h500;
        tick(); clear_reqs();
        tick();
        exc_req = 1'b1; exc_cause = 5'd9; exc_pc = 32'h600;
        tick(); clear_reqs();
        chk("d_mepc", w_mepc, 32'h500);
        tick(); tick();
        chk("d_flush", 32'(flush), 32'd0);
        chk("d_count", 32'(tcount), 32'd4);

        // Counter wrap from 0xFFFF
        force dut.trap_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        tick();
        release dut.trap_count_q;
        tick();
        chk("w_preset", 32'(tcount), 32'hFFFF);
        exc_req = 1'b1; exc_cause = 5'd4; exc_pc = 32'h640;
        tick(); clear_reqs();
        tick(); tick();
        chk("w_wrap", 32'(tcount), 32'd0);
        tick();

        // Reset during SAVE aborts the sequence
        exc_req = 1'b1; exc_cause = 5'd3; exc_pc = 32'h700;
        tick(); clear_reqs();
        tick();
        chk("x_we_before", 32'(exc_we), 32'd1);
        #2 rst = 1'b1;
        model_reset();
        #1 chk_all_zero("x_async");
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("x_no_redirect", 32'(rvalid), 32'd0);
        exc_req = 1'b1; exc_cause = 5'd1; exc_pc = 32'h900;
        tick(); clear_reqs();
        tick();
        chk("x_after_mepc", w_mepc, 32'h900);
        tick();
        chk("x_after_valid", 32'(rvalid), 32'd1);
        chk("x_after_pc", rpc, 32'h800);
        chk("x_after_count", 32'(tcount), 32'd1);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
